// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: video reads, buffered CPU writes, fill engine.
// Define FB_FILL_EN to build the hardware fill engine.
module fb_access_arbiter #(
    parameter int FB_SIZE    = 4800,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK_SYS,
    input  logic              RST,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic [2:0]        VID_DATA,
    output logic              VID_VALID,
    input  logic              CPU_WR,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [2:0]        CPU_DATA,
    output logic              CPU_FULL,
    output logic              CPU_OVF,
    input  logic              FILL_START,
    input  logic [2:0]        FILL_COLOR,
    output logic              FILL_BUSY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [2:0]        RAM_WDATA,
    input  logic [2:0]        RAM_RDATA
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [2:0]        fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nx;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [2:0]        head_data;
    logic              head_ok;
    logic [ADDR_W-1:0] addr_q;
    logic              fill_go;
    logic [ADDR_W-1:0] fill_cnt;
    logic [2:0]        fill_color;

    assign fifo_empty = (count == '0);
    assign push       = CPU_WR && !CPU_FULL;
    assign pop        = !fifo_empty && !VID_REQ;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign head_ok    = (head_addr <= FB_LAST);

    // Read data is the RAM output in the cycle after the request, masked otherwise.
    assign VID_DATA = VID_VALID ? RAM_RDATA : 3'b000;

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            VID_VALID <= 1'b0;
        end else begin
            VID_VALID <= VID_REQ;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (push) begin
            fifo_addr[wr_ptr] <= CPU_ADDR;
            fifo_data[wr_ptr] <= CPU_DATA;
        end
    end

    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + 1'b1;
        end else if (!push && pop) begin
            count_nx = count - 1'b1;
        end
    end

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            CPU_FULL <= 1'b0;
            CPU_OVF  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (CPU_WR && CPU_FULL) begin
                CPU_OVF <= 1'b1;
            end
            count    <= count_nx;
            CPU_FULL <= (count_nx == CW'(FIFO_DEPTH));
        end
    end

`ifdef FB_FILL_EN
    typedef enum logic {IDLE, FILL} fill_state_t;
    fill_state_t state;

    assign fill_go   = (state == FILL) && !VID_REQ && fifo_empty;
    assign FILL_BUSY = (state == FILL);

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            fill_color <= 3'b000;
        end else if (FILL_START) begin
            state      <= FILL;
            fill_cnt   <= '0;
            fill_color <= FILL_COLOR;
        end else if (fill_go) begin
            if (fill_cnt == FB_LAST) begin
                state    <= IDLE;
                fill_cnt <= '0;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end
`else
    logic fill_unused;
    assign fill_unused = ^{FILL_START, FILL_COLOR};
    assign fill_go     = 1'b0;
    assign fill_cnt    = '0;
    assign fill_color  = 3'b000;
    assign FILL_BUSY   = 1'b0;
`endif

    // Address holds its last value when idle or when a bad CPU entry is dropped.
    always_comb begin
        RAM_WE    = 1'b0;
        RAM_WDATA = 3'b000;
        RAM_ADDR  = addr_q;
        if (RST) begin
            RAM_WE = 1'b0;
        end else if (VID_REQ) begin
            RAM_ADDR = VID_ADDR;
        end else if (pop) begin
            if (head_ok) begin
                RAM_ADDR  = head_addr;
                RAM_WE    = 1'b1;
                RAM_WDATA = head_data;
            end
        end else if (fill_go) begin
            RAM_ADDR  = fill_cnt;
            RAM_WE    = 1'b1;
            RAM_WDATA = fill_color;
        end
    end

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            addr_q <= '0;
        end else begin
            addr_q <= RAM_ADDR;
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter; fill checks enabled with FB_FILL_EN.
module tb_fb_access_arbiter;

    logic        CLK_SYS = 1'b0;
    logic        RST;
    logic        VID_REQ;
    logic [12:0] VID_ADDR;
    logic [2:0]  VID_DATA;
    logic        VID_VALID;
    logic        CPU_WR;
    logic [12:0] CPU_ADDR;
    logic [2:0]  CPU_DATA;
    logic        CPU_FULL;
    logic        CPU_OVF;
    logic        FILL_START;
    logic [2:0]  FILL_COLOR;
    logic        FILL_BUSY;
    logic [12:0] RAM_ADDR;
    logic        RAM_WE;
    logic [2:0]  RAM_WDATA;
    logic [2:0]  RAM_RDATA;

    int n_chk  = 0;
    int n_pass = 0;

    fb_access_arbiter dut (
        .CLK_SYS    (CLK_SYS),
        .RST        (RST),
        .VID_REQ    (VID_REQ),
        .VID_ADDR   (VID_ADDR),
        .VID_DATA   (VID_DATA),
        .VID_VALID  (VID_VALID),
        .CPU_WR     (CPU_WR),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_DATA   (CPU_DATA),
        .CPU_FULL   (CPU_FULL),
        .CPU_OVF    (CPU_OVF),
        .FILL_START (FILL_START),
        .FILL_COLOR (FILL_COLOR),
        .FILL_BUSY  (FILL_BUSY),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_WE     (RAM_WE),
        .RAM_WDATA  (RAM_WDATA),
        .RAM_RDATA  (RAM_RDATA)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK_SYS);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int c;
        logic prev_req;

        RST = 1'b1;
        VID_REQ = 1'b1;
        VID_ADDR = 13'd5;
        CPU_WR = 1'b1;
        CPU_ADDR = 13'd7;
        CPU_DATA = 3'd6;
        FILL_START = 1'b0;
        FILL_COLOR = 3'd0;
        RAM_RDATA = 3'b101;
        #1;
        chk("rst_we", RAM_WE, 0);
        chk("rst_addr", RAM_ADDR, 0);
        chk("rst_wdata", RAM_WDATA, 0);
        cyc();
        cyc();
        chk("rst_vvalid", VID_VALID, 0);
        chk("rst_vdata", VID_DATA, 0);
        chk("rst_full", CPU_FULL, 0);
        chk("rst_ovf", CPU_OVF, 0);
        chk("rst_busy", FILL_BUSY, 0);
        chk("rst_addr2", RAM_ADDR, 0);
        VID_REQ = 1'b0;
        CPU_WR = 1'b0;
        RST = 1'b0;
        cyc();

        // Video read
        VID_REQ = 1'b1;
        VID_ADDR = 13'd5;
        #1;
        chk("vid_addr", RAM_ADDR, 5);
        chk("vid_we", RAM_WE, 0);
        cyc();
        VID_REQ = 1'b0;
        #1;
        chk("vid_valid", VID_VALID, 1);
        chk("vid_data", VID_DATA, 3'b101);
        chk("idle_hold_addr", RAM_ADDR, 5);
        cyc();
        chk("vid_pulse", VID_VALID, 0);

        // Fill FIFO under video pressure
        VID_REQ = 1'b1;
        VID_ADDR = 13'd9;
        for (int i = 0; i < 4; i++) begin
            CPU_WR = 1'b1;
            CPU_ADDR = 13'(i);
            CPU_DATA = 3'(i + 1);
            cyc();
        end
        chk("fifo_full", CPU_FULL, 1);
        chk("fifo_no_ovf", CPU_OVF, 0);
        chk("vid_pri_addr", RAM_ADDR, 9);
        chk("vid_pri_we", RAM_WE, 0);
        CPU_ADDR = 13'd10;
        CPU_DATA = 3'd7;
        cyc();
        CPU_WR = 1'b0;
        #1;
        chk("ovf_set", CPU_OVF, 1);
        chk("full_kept", CPU_FULL, 1);
        VID_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_we", RAM_WE, 1);
            chk("drain_addr", RAM_ADDR, 32'(i));
            chk("drain_data", RAM_WDATA, 32'(i + 1));
            cyc();
        end
        #1;
        chk("drained_we", RAM_WE, 0);
        chk("drained_wdata", RAM_WDATA, 0);
        chk("drained_addr", RAM_ADDR, 3);
        chk("drained_full", CPU_FULL, 0);
        chk("ovf_sticky", CPU_OVF, 1);

        // Out-of-range write is dropped
        CPU_WR = 1'b1;
        CPU_ADDR = 13'd4800;
        CPU_DATA = 3'd6;
        cyc();
        CPU_WR = 1'b0;
        #1;
        chk("oor_we", RAM_WE, 0);
        chk("oor_addr", RAM_ADDR, 3);
        cyc();
        chk("oor_we2", RAM_WE, 0);
        CPU_WR = 1'b1;
        CPU_ADDR = 13'd100;
        CPU_DATA = 3'd2;
        cyc();
        CPU_WR = 1'b0;
        #1;
        chk("after_oor_we", RAM_WE, 1);
        chk("after_oor_addr", RAM_ADDR, 100);
        chk("after_oor_data", RAM_WDATA, 2);
        cyc();

`ifdef FB_FILL_EN
        // Uncontended fill
        FILL_START = 1'b1;
        FILL_COLOR = 3'b010;
        #1;
        chk("fill_busy_pre", FILL_BUSY, 0);
        cyc();
        FILL_START = 1'b0;
        FILL_COLOR = 3'b101;
        bad = 0;
        for (int i = 0; i < 4800; i++) begin
            #1;
            if (!(RAM_WE === 1'b1 && RAM_ADDR === 13'(i) &&
                  RAM_WDATA === 3'b010 && FILL_BUSY === 1'b1))
                bad++;
            cyc();
        end
        #1;
        chk("fill_bad_writes", bad, 0);
        chk("fill_busy_fall", FILL_BUSY, 0);
        chk("fill_done_we", RAM_WE, 0);
        chk("fill_hold_addr", RAM_ADDR, 4799);

        // Fill with video every second cycle
        FILL_START = 1'b1;
        FILL_COLOR = 3'b011;
        cyc();
        FILL_START = 1'b0;
        c = 0;
        bad = 0;
        prev_req = 1'b0;
        while (FILL_BUSY === 1'b1 && c < 20000) begin
            VID_REQ = (c % 2 == 0);
            VID_ADDR = c[12:0];
            RAM_RDATA = c[2:0];
            #1;
            if (VID_REQ) begin
                if (RAM_WE !== 1'b0 || RAM_ADDR !== VID_ADDR) bad++;
            end else begin
                if (RAM_WE !== 1'b1 || RAM_ADDR !== 13'(c / 2) ||
                    RAM_WDATA !== 3'b011) bad++;
            end
            if (VID_VALID !== prev_req) bad++;
            if (VID_VALID === 1'b1 && VID_DATA !== RAM_RDATA) bad++;
            prev_req = VID_REQ;
            cyc();
            c++;
        end
        VID_REQ = 1'b0;
        chk("shared_fill_cycles", c, 9600);
        chk("shared_fill_bad", bad, 0);
        cyc();

        // Reset in the middle of a fill
        FILL_START = 1'b1;
        FILL_COLOR = 3'b111;
        cyc();
        FILL_START = 1'b0;
        repeat (1000) cyc();
        #1;
        chk("mid_fill_addr", RAM_ADDR, 1000);
        chk("mid_fill_we", RAM_WE, 1);
        RST = 1'b1;
        #1;
        chk("rst_mid_busy", FILL_BUSY, 0);
        chk("rst_mid_we", RAM_WE, 0);
        chk("rst_mid_wdata", RAM_WDATA, 0);
        cyc();
        cyc();
        RST = 1'b0;
        bad = 0;
        repeat (50) begin
            #1;
            if (RAM_WE !== 1'b0 || FILL_BUSY !== 1'b0) bad++;
            cyc();
        end
        chk("post_rst_quiet", bad, 0);
`else
        FILL_START = 1'b1;
        FILL_COLOR = 3'b010;
        cyc();
        FILL_START = 1'b0;
        bad = 0;
        repeat (20) begin
            #1;
            if (RAM_WE !== 1'b0 || FILL_BUSY !== 1'b0) bad++;
            cyc();
        end
        chk("no_fill_quiet", bad, 0);
        chk("no_fill_busy", FILL_BUSY, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Arbitrates the single port of the 80x60, 3-bit framebuffer RAM between video scanout reads, CPU pixel writes and a hardware fill engine. It sits between the VGA timing/scanout logic, the CPU bus capture logic and the RAM. Video scanout always has fixed priority. CPU writes are buffered in a small FIFO so the CPU never stalls. The fill engine clears the whole buffer to one colour using otherwise idle RAM cycles.

## Interface
- FB_SIZE, 4800, number of pixel words (80*60)
- ADDR_W, 13, address width; must satisfy 2^ADDR_W >= FB_SIZE
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, minimum 2

- CLK_SYS  in  1  system clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- VID_REQ  in  1  scanout read request, one cycle
- VID_ADDR  in  ADDR_W  scanout read address
- VID_DATA  out  3  read data
- VID_VALID  out  1  VID_DATA valid
- CPU_WR  in  1  push one write into the FIFO
- CPU_ADDR  in  ADDR_W  write address
- CPU_DATA  in  3  write pixel (bit0 R, bit1 G, bit2 B)
- CPU_FULL  out  1  FIFO full
- CPU_OVF  out  1  sticky overflow flag
- FILL_START  in  1  start fill, one cycle
- FILL_COLOR  in  3  fill pixel value, sampled at FILL_START
- FILL_BUSY  out  1  fill in progress
- RAM_ADDR  out  ADDR_W  RAM address
- RAM_WE  out  1  RAM write enable
- RAM_WDATA  out  3  RAM write data
- RAM_RDATA  in  3  RAM read data, synchronous, 1-cycle latency

## Operation
- One RAM access per cycle. Priority order: video read, then CPU FIFO head, then fill.
- Video: when VID_REQ=1, RAM_ADDR=VID_ADDR and RAM_WE=0 combinationally in the same cycle. Never stalled.
- CPU FIFO:
  - CPU_WR pushes {CPU_ADDR, CPU_DATA}.
  - A push while CPU_FULL=1 is dropped and sets CPU_OVF. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle when the FIFO is not full are both performed; the count is unchanged.
  - The head entry is popped and written in any cycle with VID_REQ=0.
  - Entries with address >= FB_SIZE are popped and discarded, with RAM_WE=0.
- Fill FSM, states IDLE and FILL:
  - IDLE to FILL on FILL_START. This latches FILL_COLOR and sets the counter to 0.
  - In FILL, the engine writes counter/colour and increments only in cycles where VID_REQ=0 and the FIFO is empty.
  - After writing FB_SIZE-1 it returns to IDLE.
  - FILL_START while in FILL restarts the fill from 0 with the new colour.
  - CPU writes issued during a fill to addresses not yet reached are overwritten by the fill. Software waits on FILL_BUSY=0.
- FILL_BUSY=1 exactly while the state is FILL.
- When nothing is granted: RAM_WE=0, RAM_ADDR holds its last value, RAM_WDATA=0.

## Timing
- Reset values:
  - VID_DATA=0, VID_VALID=0
  - CPU_FULL=0, CPU_OVF=0, FIFO empty
  - FILL_BUSY=0, state IDLE, counter 0
  - RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0
- Read latency: VID_REQ in cycle N gives VID_VALID=1 and VID_DATA=RAM_RDATA in cycle N+1, registered. VID_VALID is a 1-cycle pulse.
- CPU write latency: a push in cycle N can be written to RAM no earlier than cycle N+1 (registered FIFO).
- CPU_FULL is registered and updates the cycle after the push or pop that changes the count.
- Fill duration: exactly FB_SIZE cycles when uncontended.
- FILL_BUSY rises the cycle after FILL_START and falls the cycle after the last fill write.
- FILL_START and the last fill write in the same cycle: restart wins, FILL_BUSY stays 1.
- RST asserted mid-fill or mid-FIFO: all state clears immediately, pending writes are lost, and no RAM write is issued while RST=1.

## Configuration
- FB_FILL_EN defined: fill engine and FSM present as described.
- FB_FILL_EN undefined:
  - Fill logic is not built; FILL_START and FILL_COLOR are ignored.
  - FILL_BUSY is tied to 0.
  - RAM access is video, then CPU FIFO, otherwise idle.

## Test plan
- Reset, then VID_REQ with VID_ADDR=5 while RAM_RDATA returns 3'b101 -> VID_VALID=1 and VID_DATA=3'b101 in the next cycle; all outputs 0 during reset.
- Push 4 writes (addr 0..3, data 1..4) with VID_REQ held 1 -> CPU_FULL=1. A 5th push sets CPU_OVF=1 and is dropped. Releasing VID_REQ -> 4 consecutive RAM writes, addr 0..3 in order.
- Push a write to addr 4800 -> entry is popped, RAM_WE never asserted.
- With FB_FILL_EN: FILL_START with colour 3'b010, no other traffic -> 4800 writes to addr 0..4799 of 3'b010, then FILL_BUSY falls after 4800 cycles.
- Fill with VID_REQ asserted every 2nd cycle -> video read data returns with 1-cycle latency throughout, and the fill takes 9600 cycles.
- Assert RST at fill counter 1000 -> FILL_BUSY=0 and RAM_WE=0 immediately. After release, no further writes occur.
